renode_axi_burst_beat_gen: RTL and testbench
============================================

// Module: renode_axi_burst_beat_gen
// PURPOSE
//  Expands one AXI4 address-channel command (AW or AR) into per-beat address, strobe, index and last.
//  Supports FIXED, INCR and WRAP bursts, any legal narrow size up to DataWidth, and unaligned starts.
//  Sits between the AXI slave channel logic and the Renode bus-access issuer.
//  One instance serves the read path and one serves the write path.
//  Illegal commands still produce the full len+1 beats, each flagged, so the slave can answer SLVERR per beat.
// PARAMETERS
//  AddressWidth  32  width of cmd_addr and beat_addr
//  DataWidth     32  bus data width in bits; a power of two, 8..1024; StrobeWidth = DataWidth/8
// PORTS
//  aclk        in   1             clock; all logic is on the rising edge
//  areset      in   1             synchronous reset, active-high
//  cmd_valid   in   1             command offered
//  cmd_ready   out  1             command accepted when cmd_valid && cmd_ready
//  cmd_addr    in   AddressWidth  start address (AxADDR)
//  cmd_len     in   8             burst_length_t; beats-1 (AxLEN)
//  cmd_size    in   3             burst_size_t; log2 bytes per beat (AxSIZE)
//  cmd_burst   in   2             burst_type_t (AxBURST)
//  beat_valid  out  1             beat outputs are valid
//  beat_ready  in   1             downstream consumes the beat
//  beat_addr   out  AddressWidth  address of the current beat
//  beat_strb   out  StrobeWidth   active byte lanes
//  beat_index  out  8             beat number, 0..len
//  beat_last   out  1             final beat of the burst
//  beat_err    out  1             the command was illegal
//  busy        out  1             a burst is in progress
// BEHAVIOUR
//  - FSM states: IDLE and BURST. Reset puts the FSM in IDLE.
//  - Reset values: beat_valid=0, busy=0, beat_addr=0, beat_strb=0, beat_index=0, beat_last=0, beat_err=0.
//  - cmd_ready is forced to 0 while areset is high.
//  - cmd_ready = (state==IDLE) || (beat_valid && beat_ready && beat_last). This allows back-to-back bursts with no bubble.
//  - Accept moves IDLE->BURST and latches the command. Beat 0 is presented on the next cycle (latency 1), with beat_valid registered.
//  - Beat outputs hold stable while beat_valid && !beat_ready.
//  - A handshake on a non-last beat advances to the next beat in the following cycle.
//  - A handshake on the last beat returns to IDLE, or reloads directly if a new command is accepted in the same cycle.
//  - busy = (state==BURST).
//  - bytes = 1<<size. Lane offset = addr mod StrobeWidth. Aligned address = addr & ~(bytes-1).
//  - beat_strb for beat 0:
//    - Lanes from the aligned lane up to aligned lane + bytes-1 are set.
//    - Lanes below the unaligned addr offset are cleared.
//  - beat_strb for later beats covers the full bytes-wide lane group at that beat's address.
//  - FIXED: every beat uses cmd_addr and the same strobe.
//  - INCR: beat n address is cmd_addr for n=0 and aligned + n*bytes for n>0.
//  - WRAP:
//    - total = (len+1)*bytes; wrap base = addr & ~(total-1).
//    - Each next address = base + ((cur + bytes - base) mod total).
//  - Illegal command, with beat_err=1 on every beat and beat_strb=0:
//    - size > log2(StrobeWidth);
//    - burst == 2'b11;
//    - WRAP with len not in {1,3,7,15};
//    - WRAP with a start address not aligned to bytes;
//    - INCR whose last byte crosses a 4 KiB boundary;
//    - FIXED with len > 15.
//  - For illegal commands the beat count is still len+1, and addresses follow the INCR rule when computable.
//  - Address arithmetic wraps modulo 2**AddressWidth and has no overflow flag. Top-of-space wrap is covered by the 4 KiB check.
//  - Reset asserted mid-burst: on that edge beat_valid drops and the state returns to IDLE. The remaining beats are discarded.
// STRUCTURE
//  - renode_axi_pkg gains:
//    - burst type constants BurstFixed=2'b00, BurstIncr=2'b01, BurstWrap=2'b10;
//    - localparam Boundary4K=4096;
//    - function is_legal_wrap_len(burst_length_t).
//  - Sub-module renode_axi_beat_strobe (combinational): maps (addr low bits, size, first_beat) to the strobe, parametrised by StrobeWidth.
//  - The FSM, beat counter and next-address logic stay in this module.
// TESTING  (DataWidth=32)
//  - INCR addr=0x1000 len=3 size=2 -> addrs 0x1000/04/08/0C; strb 0xF; last on index 3; beat 0 one cycle after accept.
//  - WRAP addr=0x1008 len=3 size=2 -> addrs 0x1008,0x100C,0x1000,0x1004; strb 0xF; beat_err=0.
//  - INCR addr=0x1001 len=1 size=2 -> (0x1001, strb 0xE), then (0x1004, strb 0xF).
//  - Narrow INCR addr=0x3 len=1 size=0 -> (0x3, 0x8), then (0x4, 0x1).
//  - FIXED addr=0x20 len=2 size=0 -> three beats at 0x20 with strb 0x1.
//  - Stall beat_ready 3 cycles: outputs hold.
//  - Errors:
//    - size=3 -> beat_err=1, strb=0, len+1 beats.
//    - WRAP len=2 -> 3 flagged beats.
//    - INCR 0xFFC len=1 size=2 -> flagged.
//  - Back-to-back: second command accepted on the last-beat handshake gives no idle cycle.
//  - areset during beat 1 of 4 -> beat_valid=0 next edge; a fresh command then starts at index 0.

Source files
------------

// File: rtl/renode_axi_pkg.sv
// Shared AXI burst types, constants and helpers for the Renode AXI slave bridge.
package renode_axi_pkg;

  typedef logic [7:0] burst_length_t;  // AxLEN: beats - 1
  typedef logic [2:0] burst_size_t;    // AxSIZE: log2(bytes per beat)
  typedef logic [1:0] burst_type_t;    // AxBURST

  localparam burst_type_t BurstFixed = 2'b00;
  localparam burst_type_t BurstIncr  = 2'b01;
  localparam burst_type_t BurstWrap  = 2'b10;

  localparam int Boundary4K = 4096;

  typedef enum logic {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } beat_gen_state_t;

  // WRAP bursts may only be 2, 4, 8 or 16 beats long.
  function automatic logic is_legal_wrap_len(input burst_length_t len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/renode_axi_beat_strobe.sv
// Byte-lane strobe for one beat: the bytes-wide lane group containing the
// address, with lanes below an unaligned start trimmed on the first beat.
module renode_axi_beat_strobe
  import renode_axi_pkg::*;
#(
  parameter int StrobeWidth = 4,
  localparam int LaneBits = (StrobeWidth > 1) ? $clog2(StrobeWidth) : 1
) (
  input  logic [LaneBits-1:0]    i_lane,
  input  burst_size_t            i_size,
  input  logic                   i_first_beat,
  output logic [StrobeWidth-1:0] o_strb
);

  int w_offset;
  int w_bytes;
  int w_aligned;

  // Select lanes [aligned, aligned+bytes) and trim below the start offset on beat 0.
  always_comb begin
    // NOTE: every variable gets a default before any conditional use so no latch is inferred.
    w_offset  = int'(i_lane) % StrobeWidth;  // %1 collapses the 8-bit bus case to lane 0
    w_bytes   = 1 << i_size;
    w_aligned = w_offset & ~(w_bytes - 1);
    o_strb    = '0;
    for (int i = 0; i < StrobeWidth; i++) begin
      o_strb[i] = (i >= w_aligned) && (i < w_aligned + w_bytes) &&
                  (!i_first_beat || (i >= w_offset));
    end
  end

endmodule

// File: rtl/renode_axi_burst_beat_gen.sv
// Expands one AXI4 AW/AR command into per-beat address, strobe, index and last.
// Illegal commands still yield len+1 beats, each flagged with beat_err.
module renode_axi_burst_beat_gen
  import renode_axi_pkg::*;
#(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  localparam int StrobeWidth = DataWidth / 8
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [AddressWidth-1:0] cmd_addr,
  input  burst_length_t           cmd_len,
  input  burst_size_t             cmd_size,
  input  burst_type_t             cmd_burst,
  output logic                    beat_valid,
  input  logic                    beat_ready,
  output logic [AddressWidth-1:0] beat_addr,
  output logic [StrobeWidth-1:0]  beat_strb,
  output logic [7:0]              beat_index,
  output logic                    beat_last,
  output logic                    beat_err,
  output logic                    busy
);

  localparam int MaxSize  = (StrobeWidth > 1) ? $clog2(StrobeWidth) : 0;
  localparam int LaneBits = (StrobeWidth > 1) ? $clog2(StrobeWidth) : 1;

  beat_gen_state_t r_state;
  beat_gen_state_t w_next_state;

  // Latched command and beat position
  logic [AddressWidth-1:0] r_addr;
  logic [AddressWidth-1:0] r_wrap_mask;
  burst_length_t           r_len;
  burst_size_t             r_size;
  burst_type_t             r_burst;   // effective burst; illegal commands walk as INCR
  logic [7:0]              r_index;
  logic                    r_err;

  // Command decode
  logic [AddressWidth-1:0] w_cmd_bytes;
  logic [AddressWidth-1:0] w_cmd_wrap_mask;
  logic [11:0]             w_cmd_page_off;
  logic [16:0]             w_cmd_total;
  logic [16:0]             w_incr_end;
  logic                    w_cmd_err;

  // Current beat
  logic [AddressWidth-1:0] w_bytes;
  logic [AddressWidth-1:0] w_bytes_m1;
  logic [AddressWidth-1:0] w_next_addr;
  logic [StrobeWidth-1:0]  w_strb;
  logic                    w_last;
  logic                    w_hs;
  logic                    w_accept;
  logic                    w_advance;

  // Legality of the offered command, evaluated before it is latched.
  always_comb begin
    w_cmd_bytes     = AddressWidth'(1) << cmd_size;
    w_cmd_wrap_mask = (AddressWidth'({1'b0, cmd_len} + 9'd1) << cmd_size) - AddressWidth'(1);
    w_cmd_page_off  = cmd_addr[11:0] & ~(w_cmd_bytes[11:0] - 12'd1);
    w_cmd_total     = 17'({1'b0, cmd_len} + 9'd1) << cmd_size;
    // Byte offset of the last byte relative to the start page; >= 4 KiB means it
    // crossed a page, which also catches wrapping past the top of address space.
    w_incr_end      = {5'b0, w_cmd_page_off} + w_cmd_total - 17'd1;
    w_cmd_err = (int'(cmd_size) > MaxSize) ||
                (cmd_burst == 2'b11) ||
                ((cmd_burst == BurstWrap) && !is_legal_wrap_len(cmd_len)) ||
                ((cmd_burst == BurstWrap) && ((cmd_addr & (w_cmd_bytes - AddressWidth'(1))) != '0)) ||
                ((cmd_burst == BurstIncr) && (w_incr_end >= 17'(Boundary4K))) ||
                ((cmd_burst == BurstFixed) && (cmd_len > 8'd15));
  end

  // Address of the beat after the current one.
  always_comb begin
    w_bytes    = AddressWidth'(1) << r_size;
    w_bytes_m1 = w_bytes - AddressWidth'(1);
    w_last     = (r_index == r_len);
    case (r_burst)
      BurstFixed: w_next_addr = r_addr;
      // Wrap window is power-of-two sized and aligned, so base + ((cur+bytes-base) mod total)
      // reduces to keeping the high bits and wrapping the low bits.
      BurstWrap:  w_next_addr = (r_addr & ~r_wrap_mask) | ((r_addr + w_bytes) & r_wrap_mask);
      default:    w_next_addr = (r_addr & ~w_bytes_m1) + w_bytes;
    endcase
  end

  // Next-state and handshake decode.
  always_comb begin
    w_next_state = r_state;
    w_hs         = beat_valid && beat_ready;
    cmd_ready    = !areset && ((r_state == StIdle) || (w_hs && w_last));
    w_accept     = cmd_valid && cmd_ready;
    w_advance    = w_hs && !w_last;
    case (r_state)
      StIdle:  if (w_accept) w_next_state = StBurst;
      StBurst: if (w_hs && w_last && !w_accept) w_next_state = StIdle;
      default: w_next_state = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (areset) r_state <= StIdle;
    else        r_state <= w_next_state;
  end

  // Command latch and beat walk.
  always_ff @(posedge aclk) begin
    // NOTE: all datapath flops are reset because beat_addr/beat_index are visible after reset.
    if (areset) begin
      r_addr      <= '0;
      r_wrap_mask <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= BurstIncr;
      r_index     <= '0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_addr      <= cmd_addr;
      r_wrap_mask <= w_cmd_wrap_mask;
      r_len       <= cmd_len;
      r_size      <= cmd_size;
      r_burst     <= w_cmd_err ? BurstIncr : cmd_burst;
      r_index     <= '0;
      r_err       <= w_cmd_err;
    end else if (w_advance) begin
      r_addr      <= w_next_addr;
      r_index     <= r_index + 8'd1;
    end
  end

  // FIXED repeats the first-beat strobe on every beat.
  renode_axi_beat_strobe #(
    .StrobeWidth (StrobeWidth)
  ) u_strobe (
    .i_lane       (r_addr[LaneBits-1:0]),
    .i_size       (r_size),
    .i_first_beat ((r_index == 8'd0) || (r_burst == BurstFixed)),
    .o_strb       (w_strb)
  );

  assign beat_valid = (r_state == StBurst);
  assign busy       = (r_state == StBurst);
  assign beat_addr  = r_addr;
  assign beat_index = r_index;
  assign beat_last  = beat_valid && w_last;
  assign beat_err   = beat_valid && r_err;
  assign beat_strb  = (beat_valid && !r_err) ? w_strb : '0;

endmodule

// File: tb/tb_renode_axi_burst_beat_gen.sv
// Scoreboard bench: the driver pushes the expected beats of each accepted
// command; a monitor pops and compares on every beat handshake.
module tb_renode_axi_burst_beat_gen;
  import renode_axi_pkg::*;

  localparam int SW = 4;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        beat_valid, beat_ready = 1'b0;
  logic [31:0] beat_addr;
  logic [3:0]  beat_strb;
  logic [7:0]  beat_index;
  logic        beat_last, beat_err, busy;

  renode_axi_burst_beat_gen #(.AddressWidth(32), .DataWidth(32)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
    .beat_strb(beat_strb), .beat_index(beat_index), .beat_last(beat_last),
    .beat_err(beat_err), .busy(busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [7:0]  index;
    logic        last;
    logic        err;
  } beat_t;

  beat_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    rdy_force = 1;    // <0: random ready, otherwise fixed value
  logic  b2b_on_last = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Lanes touched by the bytes actually transferred in one beat.
  function automatic logic [3:0] lanes(input longint a, input longint bytes, input bit first);
    longint aligned = a & ~(bytes - 1);
    longint lo = first ? a : aligned;
    logic [3:0] s = '0;
    for (longint b = lo; b < aligned + bytes; b++) s[int'(b % SW)] = 1'b1;
    return s;
  endfunction

  // Reference model: full list of beats for one command.
  task automatic push_expected(input logic [31:0] addr, input int len, input int size, input logic [1:0] burst);
    longint a = longint'(addr);
    longint bytes = longint'(1) << size;
    longint aligned = a & ~(bytes - 1);
    longint total = longint'(len + 1) * bytes;
    longint base = a & ~(total - 1);
    longint cur = a;
    bit err;
    beat_t b;
    err = (size > 2) || (burst == 2'b11) ||
          ((burst == BurstWrap) && !(len inside {1, 3, 7, 15})) ||
          ((burst == BurstWrap) && (a % bytes != 0)) ||
          ((burst == BurstIncr) && ((aligned >> 12) != ((aligned + total - 1) >> 12))) ||
          ((burst == BurstFixed) && (len > 15));
    for (int n = 0; n <= len; n++) begin
      if (err || burst == BurstIncr) cur = (n == 0) ? a : ((aligned + n * bytes) & 64'hFFFF_FFFF);
      else if (burst == BurstFixed)  cur = a;
      else if (n > 0)                cur = base + ((cur + bytes - base) % total);
      b.addr  = cur[31:0];
      b.strb  = err ? 4'h0 : lanes(cur, bytes, (n == 0) || (burst == BurstFixed));
      b.index = 8'(n);
      b.last  = (n == len);
      b.err   = err;
      sb.push_back(b);
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] addr, input int len, input int size, input logic [1:0] burst);
    cmd_addr = addr; cmd_len = 8'(len); cmd_size = 3'(size); cmd_burst = burst;
    cmd_valid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge aclk);
      if (cmd_ready) begin
        b2b_on_last = beat_valid && beat_last;
        push_expected(addr, len, size, burst);
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        return;
      end
      @(posedge aclk); #1;
    end
    cmd_valid = 1'b0;
    fail("cmd_accept_timeout");
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 3000; t++) begin
      @(posedge aclk); #1;
      if (sb.size() == 0 && !busy) return;
    end
    fail("drain_timeout");
    sb.delete();
  endtask

  // Downstream ready, changed away from the sampling edge.
  initial forever begin
    @(posedge aclk); #2;
    beat_ready = (rdy_force < 0) ? ($urandom_range(0, 3) != 0) : rdy_force[0];
  end

  // Monitor: compare every consumed beat against the scoreboard head.
  always @(negedge aclk) begin
    beat_t e;
    if (!areset && beat_valid && beat_ready) begin
      if (sb.size() == 0) begin
        fail("unexpected_beat");
      end else begin
        e = sb.pop_front();
        check("beat_addr",  64'(beat_addr),  64'(e.addr));
        check("beat_strb",  64'(beat_strb),  64'(e.strb));
        check("beat_index", 64'(beat_index), 64'(e.index));
        check("beat_last",  64'(beat_last),  64'(e.last));
        check("beat_err",   64'(beat_err),   64'(e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    int len, size, sel;
    logic [1:0] burst;

    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_beat_valid", 64'(beat_valid), 64'(0));
    check("rst_busy",       64'(busy),       64'(0));
    check("rst_beat_addr",  64'(beat_addr),  64'(0));
    check("rst_beat_strb",  64'(beat_strb),  64'(0));
    check("rst_beat_index", 64'(beat_index), 64'(0));
    check("rst_beat_last",  64'(beat_last),  64'(0));
    check("rst_beat_err",   64'(beat_err),   64'(0));
    check("rst_cmd_ready",  64'(cmd_ready),  64'(0));
    @(posedge aclk); #1;
    areset = 1'b0;

    // Directed vectors with downstream always ready
    rdy_force = 1;
    send(32'h1000, 3, 2, BurstIncr);
    @(negedge aclk);
    check("latency_valid", 64'(beat_valid), 64'(1));
    check("latency_index", 64'(beat_index), 64'(0));
    @(posedge aclk); #1;
    send(32'h1008, 3, 2, BurstWrap);
    send(32'h1001, 1, 2, BurstIncr);
    send(32'h0003, 1, 0, BurstIncr);
    send(32'h0020, 2, 0, BurstFixed);
    send(32'h0100, 2, 3, BurstIncr);   // size too large
    send(32'h1000, 2, 2, BurstWrap);   // illegal wrap length
    send(32'h0FFC, 1, 2, BurstIncr);   // crosses 4 KiB
    wait_drain();

    // Back-to-back: second command taken on the last-beat handshake
    send(32'h2000, 1, 2, BurstIncr);
    send(32'h3000, 1, 2, BurstIncr);
    check("b2b_on_last", 64'(b2b_on_last), 64'(1));
    @(negedge aclk);
    check("b2b_valid", 64'(beat_valid), 64'(1));
    check("b2b_index", 64'(beat_index), 64'(0));
    @(posedge aclk); #1;
    wait_drain();

    // Stall: beat 0 holds while ready is low
    rdy_force = 0;
    send(32'h1000, 3, 2, BurstIncr);
    repeat (4) begin
      @(negedge aclk);
      check("stall_valid", 64'(beat_valid), 64'(1));
      check("stall_addr",  64'(beat_addr),  64'(32'h1000));
      check("stall_strb",  64'(beat_strb),  64'(4'hF));
      check("stall_index", 64'(beat_index), 64'(0));
    end
    rdy_force = 1;
    @(posedge aclk); #1;
    wait_drain();

    // Reset during beat 1 of 4
    rdy_force = 0;
    send(32'h4000, 3, 2, BurstIncr);
    @(negedge aclk); rdy_force = 1;
    @(negedge aclk); rdy_force = 0;      // beat 0 consumed at the next edge
    @(negedge aclk);
    check("rst_mid_index", 64'(beat_index), 64'(1));
    areset = 1'b1;
    @(negedge aclk);
    check("rst_mid_valid",     64'(beat_valid), 64'(0));
    check("rst_mid_busy",      64'(busy),       64'(0));
    check("rst_mid_cmd_ready", 64'(cmd_ready),  64'(0));
    sb.delete();
    @(posedge aclk); #1;
    areset = 1'b0;
    rdy_force = 1;
    send(32'h5000, 1, 2, BurstIncr);
    @(negedge aclk);
    check("post_rst_valid", 64'(beat_valid), 64'(1));
    check("post_rst_index", 64'(beat_index), 64'(0));
    @(posedge aclk); #1;
    wait_drain();

    // Randomized commands with random downstream ready
    rdy_force = -1;
    repeat (150) begin
      sel   = $urandom_range(0, 9);
      burst = (sel < 3) ? BurstFixed : (sel < 6) ? BurstIncr : (sel < 9) ? BurstWrap : 2'b11;
      size  = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2);
      case (burst)
        BurstWrap: begin
          case ($urandom_range(0, 5))
            0: len = 1;
            1: len = 3;
            2: len = 7;
            3: len = 15;
            4: len = 3;
            default: len = $urandom_range(0, 15);
          endcase
        end
        BurstFixed: len = $urandom_range(0, 17);
        default:    len = $urandom_range(0, 31);
      endcase
      addr = $urandom;
      case ($urandom_range(0, 5))
        0, 1: addr = {addr[31:12], 4'hF, addr[7:0]};
        2:    addr = {28'hFFFF_FFF, addr[3:0]};
        default: ;
      endcase
      if (burst == BurstWrap && size <= 2 && $urandom_range(0, 5) != 0)
        addr = addr & ~((32'd1 << size) - 32'd1);
      send(addr, len, size, burst);
    end
    wait_drain();
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
